// File: rtl/mul_share_arbiter.sv
// Round-robin arbiter sharing one W-bit unsigned multiplier among NREQ requesters.
// One transaction per three cycles: grant, compute, done.
module mul_share_arbiter #(
  parameter int W    = 16,
  parameter int NREQ = 4,
  localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*W-1:0] a_in,
  input  logic [NREQ*W-1:0] b_in,
  output logic [NREQ-1:0]   gnt,
  output logic [NREQ-1:0]   done,
  output logic [W-1:0]      y,
  output logic [IDW-1:0]    owner,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [IDW-1:0]    ptr_q, ptr_d;
  logic [W-1:0]      a_q, a_d;
  logic [W-1:0]      b_q, b_d;
  logic [NREQ-1:0]   gnt_q, gnt_d;
  logic [NREQ-1:0]   done_q, done_d;
  logic [W-1:0]      y_q, y_d;
  logic [IDW-1:0]    owner_q, owner_d;
  logic              busy_q, busy_d;

  logic              found;
  logic [IDW-1:0]    sel;
  logic [IDW-1:0]    sel_nxt;
  logic [W-1:0]      a_sel;
  logic [W-1:0]      b_sel;

  // Search ptr, ptr+1, ... wrapping at NREQ (not necessarily a power of two).
  always_comb begin
    logic [IDW:0] j;
    found = 1'b0;
    sel   = '0;
    j     = '0;
    for (int k = 0; k < NREQ; k++) begin
      j = {1'b0, ptr_q} + (IDW+1)'(k);
      if (j >= (IDW+1)'(NREQ)) begin
        j = j - (IDW+1)'(NREQ);
      end
      if (!found && req[j[IDW-1:0]]) begin
        found = 1'b1;
        sel   = j[IDW-1:0];
      end
    end
  end

  always_comb begin
    if (sel == IDW'(NREQ-1)) begin
      sel_nxt = '0;
    end else begin
      sel_nxt = sel + IDW'(1);
    end
  end

  always_comb begin
    a_sel = '0;
    b_sel = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (sel == IDW'(i)) begin
        a_sel = a_in[i*W +: W];
        b_sel = b_in[i*W +: W];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    a_d     = a_q;
    b_d     = b_q;
    gnt_d   = '0;
    done_d  = '0;
    y_d     = y_q;
    owner_d = owner_q;
    unique case (state_q)
      IDLE: begin
        if (found) begin
          a_d     = a_sel;
          b_d     = b_sel;
          gnt_d   = NREQ'(1) << sel;
          owner_d = sel;
          ptr_d   = sel_nxt;
          state_d = CALC;
        end
      end
      CALC: begin
        // W-bit context keeps only the low W bits of the product.
        y_d     = a_q * b_q;
        done_d  = NREQ'(1) << owner_q;
        state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      gnt_q   <= '0;
      done_q  <= '0;
      y_q     <= '0;
      owner_q <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      a_q     <= a_d;
      b_q     <= b_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
      y_q     <= y_d;
      owner_q <= owner_d;
      busy_q  <= busy_d;
    end
  end

  assign gnt   = gnt_q;
  assign done  = done_q;
  assign y     = y_q;
  assign owner = owner_q;
  assign busy  = busy_q;

endmodule

// File: tb/tb_mul_share_arbiter.sv
// Randomized self-checking bench for mul_share_arbiter against a
// transaction-level round-robin reference model.
module tb_mul_share_arbiter;

  localparam int W    = 16;
  localparam int NREQ = 4;
  localparam int IDW  = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic [NREQ-1:0]   req;
  logic [NREQ*W-1:0] a_in;
  logic [NREQ*W-1:0] b_in;
  logic [NREQ-1:0]   gnt;
  logic [NREQ-1:0]   done;
  logic [W-1:0]      y;
  logic [IDW-1:0]    owner;
  logic              busy;

  int checks = 0;
  int errors = 0;

  int          m_ptr;
  logic [W-1:0] m_y;
  int          m_owner;

  logic [NREQ-1:0] o_gnt, o_gnt2, o_done, o_done1, o_done3;
  logic [W-1:0]    o_y;
  logic [IDW-1:0]  o_owner;
  logic            o_busy1, o_busy2, o_busy3;

  mul_share_arbiter #(.W(W), .NREQ(NREQ)) dut (
    .clk   (clk),
    .rst   (rst),
    .req   (req),
    .a_in  (a_in),
    .b_in  (b_in),
    .gnt   (gnt),
    .done  (done),
    .y     (y),
    .owner (owner),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  function automatic int pick(logic [NREQ-1:0] r, int p);
    for (int k = 0; k < NREQ; k++) begin
      if (r[(p + k) % NREQ]) return (p + k) % NREQ;
    end
    return -1;
  endfunction

  function automatic logic [W-1:0] mulw(logic [W-1:0] a, logic [W-1:0] b);
    longint p;
    p = longint'(a) * longint'(b);
    return W'(p % (longint'(1) << W));
  endfunction

  function automatic logic [W-1:0] opa(int i);
    logic [NREQ*W-1:0] v;
    v = a_in;
    return v[i*W +: W];
  endfunction

  function automatic logic [W-1:0] opb(int i);
    logic [NREQ*W-1:0] v;
    v = b_in;
    return v[i*W +: W];
  endfunction

  task automatic set_ops(int i, logic [W-1:0] a, logic [W-1:0] b);
    a_in[i*W +: W] = a;
    b_in[i*W +: W] = b;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    m_ptr = 0;
    m_y = '0;
    m_owner = 0;
  endtask

  // Runs one grant/calc/done sequence; the granted requester drops req.
  task automatic serve();
    @(negedge clk);
    o_gnt   = gnt;
    o_owner = owner;
    o_busy1 = busy;
    o_done1 = done;
    req     = req & ~gnt;
    @(negedge clk);
    o_done  = done;
    o_y     = y;
    o_gnt2  = gnt;
    o_busy2 = busy;
    @(negedge clk);
    o_done3 = done;
    o_busy3 = busy;
  endtask

  // Advances the reference model for the transaction the current req starts.
  task automatic model_txn(output int idx, output logic [W-1:0] ey);
    idx = pick(req, m_ptr);
    ey = mulw(opa(idx), opb(idx));
    m_ptr = (idx + 1) % NREQ;
    m_y = ey;
    m_owner = idx;
  endtask

  task automatic test_reset();
    req = '0;
    a_in = '0;
    b_in = '0;
    do_reset();
    checks++;
    if ({gnt, done, y, owner, busy} !== '0) begin
      errors++;
      $display("FAIL reset: gnt=%b done=%b y=%h owner=%0d busy=%b, want all 0",
               gnt, done, y, owner, busy);
    end
  endtask

  task automatic test_single();
    int idx;
    logic [W-1:0] ey;
    set_ops(2, 16'd3, 16'd5);
    req = 4'b0100;
    model_txn(idx, ey);
    serve();
    checks++;
    if ({o_gnt, o_owner, o_busy1, o_done1} !== {4'b0100, 2'd2, 1'b1, 4'b0000}) begin
      errors++;
      $display("FAIL single_grant: gnt=%b owner=%0d busy=%b done=%b, want 0100 2 1 0000",
               o_gnt, o_owner, o_busy1, o_done1);
    end
    checks++;
    if ({o_done, o_y, o_gnt2, o_busy2} !== {4'b0100, 16'd15, 4'b0000, 1'b1}) begin
      errors++;
      $display("FAIL single_done: done=%b y=%0d gnt=%b busy=%b, want 0100 15 0000 1",
               o_done, o_y, o_gnt2, o_busy2);
    end
    checks++;
    if ({o_done3, o_busy3} !== 5'b0) begin
      errors++;
      $display("FAIL single_end: done=%b busy=%b, want 0000 0", o_done3, o_busy3);
    end
    if (ey !== 16'd15) $display("note: model y=%0d", ey);
  endtask

  task automatic test_contention();
    int idx;
    logic [W-1:0] ey;
    do_reset();
    for (int i = 0; i < NREQ; i++) begin
      set_ops(i, W'($urandom), W'($urandom));
    end
    req = 4'b1111;
    for (int n = 0; n < NREQ; n++) begin
      model_txn(idx, ey);
      serve();
      checks++;
      if (idx != n || o_gnt !== 4'(1 << n) || o_done !== 4'(1 << n) ||
          o_y !== ey || o_owner !== IDW'(n)) begin
        errors++;
        $display("FAIL contention[%0d]: gnt=%b done=%b y=%h owner=%0d, want gnt=%b y=%h",
                 n, o_gnt, o_done, o_y, o_owner, 4'(1 << n), ey);
      end
    end
  endtask

  task automatic test_rr_wrap();
    int idx;
    logic [W-1:0] ey;
    do_reset();
    set_ops(0, 16'd7, 16'd9);
    set_ops(1, 16'd11, 16'd13);
    req = 4'b0010;
    model_txn(idx, ey);
    serve();
    req = 4'b0011;
    model_txn(idx, ey);
    serve();
    checks++;
    if (o_gnt !== 4'b0001 || o_y !== 16'd63) begin
      errors++;
      $display("FAIL rr_wrap_first: gnt=%b y=%0d, want 0001 63", o_gnt, o_y);
    end
    model_txn(idx, ey);
    serve();
    checks++;
    if (o_gnt !== 4'b0010 || o_y !== 16'd143 || o_owner !== 2'd1) begin
      errors++;
      $display("FAIL rr_wrap_second: gnt=%b y=%0d owner=%0d, want 0010 143 1",
               o_gnt, o_y, o_owner);
    end
  endtask

  task automatic test_truncation();
    logic [W-1:0] av[3] = '{16'h0100, 16'hFFFF, 16'h00FF};
    logic [W-1:0] bv[3] = '{16'h0100, 16'hFFFF, 16'h0101};
    logic [W-1:0] yv[3] = '{16'h0000, 16'h0001, 16'hFFFF};
    int idx;
    logic [W-1:0] ey;
    for (int t = 0; t < 3; t++) begin
      set_ops(3, av[t], bv[t]);
      req = 4'b1000;
      model_txn(idx, ey);
      serve();
      checks++;
      if (o_y !== yv[t] || o_done !== 4'b1000) begin
        errors++;
        $display("FAIL truncation[%0d]: y=%h done=%b, want %h 1000",
                 t, o_y, o_done, yv[t]);
      end
    end
  endtask

  task automatic test_reset_mid();
    int idx;
    logic [W-1:0] ey;
    set_ops(2, 16'd21, 16'd3);
    req = 4'b0100;
    @(negedge clk);
    req = 4'b0000;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    m_ptr = 0;
    m_y = '0;
    m_owner = 0;
    checks++;
    if ({gnt, done, y, owner, busy} !== '0) begin
      errors++;
      $display("FAIL reset_mid: gnt=%b done=%b y=%h owner=%0d busy=%b, want all 0",
               gnt, done, y, owner, busy);
    end
    @(negedge clk);
    checks++;
    if (done !== '0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_nodone: done=%b busy=%b, want 0000 0", done, busy);
    end
    set_ops(1, 16'd4, 16'd6);
    set_ops(3, 16'd8, 16'd8);
    req = 4'b1010;
    model_txn(idx, ey);
    serve();
    checks++;
    if (o_gnt !== 4'b0010 || o_y !== 16'd24 || idx != 1) begin
      errors++;
      $display("FAIL reset_mid_regrant: gnt=%b y=%0d, want 0010 24", o_gnt, o_y);
    end
    req = '0;
  endtask

  task automatic test_idle_hold();
    req = '0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      a_in = {NREQ*W{1'b0}} | {$urandom, $urandom};
      checks++;
      if (busy !== 1'b0 || gnt !== '0 || done !== '0 ||
          y !== m_y || owner !== IDW'(m_owner)) begin
        errors++;
        $display("FAIL idle_hold[%0d]: busy=%b gnt=%b done=%b y=%h owner=%0d, want y=%h owner=%0d",
                 c, busy, gnt, done, y, owner, m_y, m_owner);
      end
    end
  endtask

  task automatic test_random();
    int idx;
    logic [W-1:0] ey;
    for (int n = 0; n < 60; n++) begin
      for (int i = 0; i < NREQ; i++) begin
        set_ops(i, W'($urandom), W'($urandom));
      end
      req = NREQ'($urandom);
      if (req == '0) begin
        @(negedge clk);
        checks++;
        if (gnt !== '0 || busy !== 1'b0 || y !== m_y) begin
          errors++;
          $display("FAIL random_idle[%0d]: gnt=%b busy=%b y=%h, want 0000 0 %h",
                   n, gnt, busy, y, m_y);
        end
      end else begin
        model_txn(idx, ey);
        serve();
        checks++;
        if (o_gnt !== 4'(1 << idx) || o_done !== 4'(1 << idx) || o_y !== ey ||
            o_owner !== IDW'(idx) || o_gnt2 !== '0 || o_done1 !== '0) begin
          errors++;
          $display("FAIL random[%0d]: gnt=%b done=%b y=%h owner=%0d, want gnt=%b y=%h",
                   n, o_gnt, o_done, o_y, o_owner, 4'(1 << idx), ey);
        end
      end
    end
    req = '0;
  endtask

  initial begin
    rst = 1'b1;
    req = '0;
    a_in = '0;
    b_in = '0;
    test_reset();
    test_single();
    test_contention();
    test_rr_wrap();
    test_truncation();
    test_reset_mid();
    test_idle_hold();
    test_random();
    test_idle_hold();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
